// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between write-back (primary) and a queued auxiliary writer.
// Optional starvation guard enabled by defining RF_ARB_STARVE_EN.
module regfile_write_arbiter #(
  parameter int unsigned AUX_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_we,
  input  logic [4:0]                   wb_rd,
  input  logic [31:0]                  wb_data,
  input  logic                         aux_valid,
  output logic                         aux_ready,
  input  logic [4:0]                   aux_rd,
  input  logic [31:0]                  aux_data,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic                         stall_req,
  output logic [$clog2(AUX_DEPTH):0]   aux_count
);

  localparam int unsigned PW = $clog2(AUX_DEPTH);
  localparam int unsigned CW = PW + 1;

  generate
    if (AUX_DEPTH != 2 && AUX_DEPTH != 4 && AUX_DEPTH != 8) begin : g_bad_depth
      $error("AUX_DEPTH must be 2, 4 or 8");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
      $error("STARVE_MAX must be in 1..15");
    end
  endgenerate

  logic [4:0]    q_rd   [AUX_DEPTH];
  logic [31:0]   q_data [AUX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic q_empty;
  logic wb_valid;
  logic push;
  logic issue_wb;
  logic issue_aux;

  assign q_empty   = (count == '0);
  assign wb_valid  = wb_we && (wb_rd != '0);
  assign aux_ready = (count < CW'(AUX_DEPTH));
  // Writes to x0 are consumed (handshake completes) but never queued.
  assign push      = aux_valid && aux_ready && (aux_rd != '0);
  assign aux_count = count;

  always_comb begin
    issue_wb  = 1'b0;
    issue_aux = 1'b0;
    if (stall_req && !q_empty) begin
      issue_aux = 1'b1;
    end else if (wb_valid) begin
      issue_wb = 1'b1;
    end else if (!q_empty) begin
      issue_aux = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= aux_rd;
      q_data[wr_ptr] <= aux_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue_aux) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, issue_aux})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= issue_wb || issue_aux;
      if (issue_aux) begin
        rf_waddr <= q_rd[rd_ptr];
        rf_wdata <= q_data[rd_ptr];
      end else if (issue_wb) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
    end
  end

`ifdef RF_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       stall_nxt;

  always_comb begin
    starve_nxt = starve_cnt;
    if (q_empty || issue_aux) begin
      starve_nxt = '0;
    end else if (issue_wb && (starve_cnt < 4'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + 1'b1;
    end
    // The stall cycle always pops, so the counter clears and the pulse stays one cycle wide.
    stall_nxt = (starve_nxt == 4'(STARVE_MAX)) && !stall_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      stall_req  <= stall_nxt;
    end
  end
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (AUX_DEPTH=2, STARVE_MAX=4).
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [1:0]  aux_count;

  int checks = 0;
  int fails  = 0;

  regfile_write_arbiter #(.AUX_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_rd    (aux_rd),
    .aux_data  (aux_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_req (stall_req),
    .aux_count (aux_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    aux_valid = 1'b0;
    aux_rd    = '0;
    aux_data  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin fails++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin fails++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
    checks++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b want 0", stall_req); end
    checks++; if (aux_count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", aux_count); end
    checks++; if (aux_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", aux_ready); end
  endtask

  task automatic test_primary();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    checks++; if (rf_we !== 1'b1) begin fails++; $display("FAIL prim_we got %0b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL prim_waddr got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL prim_wdata got %h want deadbeef", rf_wdata); end
    wb_rd = 5'd0; wb_data = 32'h00000123;
    tick();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL prim_x0_we got %0b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL prim_x0_hold_addr got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL prim_x0_hold_data got %h want deadbeef", rf_wdata); end
    idle_inputs();
    tick();
  endtask

  task automatic test_aux_fill_drain();
    // Aux write to x0 is swallowed
    aux_valid = 1'b1; aux_rd = 5'd0; aux_data = 32'h99;
    tick();
    checks++; if (aux_count !== 2'd0) begin fails++; $display("FAIL aux_x0_count got %0d want 0", aux_count); end
    aux_valid = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL aux_x0_we got %0b want 0", rf_we); end

    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h1;
    aux_valid = 1'b1; aux_rd = 5'd3; aux_data = 32'h11;
    tick();
    checks++; if (aux_count !== 2'd1) begin fails++; $display("FAIL fill_count1 got %0d want 1", aux_count); end
    checks++; if (rf_waddr !== 5'd7) begin fails++; $display("FAIL fill_prim_addr got %0d want 7", rf_waddr); end
    aux_rd = 5'd4; aux_data = 32'h22;
    tick();
    checks++; if (aux_count !== 2'd2) begin fails++; $display("FAIL fill_count2 got %0d want 2", aux_count); end
    checks++; if (aux_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %0b want 0", aux_ready); end
    aux_rd = 5'd9; aux_data = 32'h33;
    tick();
    checks++; if (aux_count !== 2'd2) begin fails++; $display("FAIL full_reject_count got %0d want 2", aux_count); end
    idle_inputs();
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      fails++; $display("FAIL drain1 got we=%0b rd=%0d d=%h want we=1 rd=3 d=11", rf_we, rf_waddr, rf_wdata); end
    checks++; if (aux_count !== 2'd1) begin fails++; $display("FAIL drain1_count got %0d want 1", aux_count); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      fails++; $display("FAIL drain2 got we=%0b rd=%0d d=%h want we=1 rd=4 d=22", rf_we, rf_waddr, rf_wdata); end
    checks++; if (aux_count !== 2'd0) begin fails++; $display("FAIL drain2_count got %0d want 0", aux_count); end
    tick();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL drain_done_we got %0b want 0", rf_we); end
  endtask

  task automatic test_contention();
    wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0A0A0A0;
    aux_valid = 1'b1; aux_rd = 5'd11; aux_data = 32'hB1B1B1B1;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA0A0A0A0) begin
      fails++; $display("FAIL cont_prim got we=%0b rd=%0d d=%h want we=1 rd=10 d=a0a0a0a0", rf_we, rf_waddr, rf_wdata); end
    idle_inputs();
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hB1B1B1B1) begin
      fails++; $display("FAIL cont_aux got we=%0b rd=%0d d=%h want we=1 rd=11 d=b1b1b1b1", rf_we, rf_waddr, rf_wdata); end
    checks++; if (aux_count !== 2'd0) begin fails++; $display("FAIL cont_count got %0d want 0", aux_count); end
    tick();
  endtask

`ifdef RF_ARB_STARVE_EN
  task automatic test_starvation();
    aux_valid = 1'b1; aux_rd = 5'd20; aux_data = 32'hA5;
    for (int unsigned i = 1; i <= 5; i++) begin
      wb_we = 1'b1; wb_rd = 5'(i); wb_data = 32'd100 + i;
      tick();
      aux_valid = 1'b0;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i)) begin
        fails++; $display("FAIL starve_prim%0d got we=%0b rd=%0d want we=1 rd=%0d", i, rf_we, rf_waddr, i); end
      checks++; if (stall_req !== (i == 5)) begin
        fails++; $display("FAIL starve_stall%0d got %0b want %0b", i, stall_req, (i == 5)); end
    end
    wb_rd = 5'd6; wb_data = 32'd106;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'hA5) begin
      fails++; $display("FAIL starve_aux got we=%0b rd=%0d d=%h want we=1 rd=20 d=a5", rf_we, rf_waddr, rf_wdata); end
    checks++; if (stall_req !== 1'b0) begin fails++; $display("FAIL starve_stall_end got %0b want 0", stall_req); end
    checks++; if (aux_count !== 2'd0) begin fails++; $display("FAIL starve_count got %0d want 0", aux_count); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'd106) begin
      fails++; $display("FAIL starve_held got we=%0b rd=%0d d=%0d want we=1 rd=6 d=106", rf_we, rf_waddr, rf_wdata); end
    idle_inputs();
    tick();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL starve_idle got %0b want 0", rf_we); end
  endtask
`else
  task automatic test_starvation();
    aux_valid = 1'b1; aux_rd = 5'd20; aux_data = 32'hA5;
    for (int unsigned i = 1; i <= 20; i++) begin
      wb_we = 1'b1; wb_rd = 5'(i); wb_data = 32'd100 + i;
      tick();
      aux_valid = 1'b0;
      checks++; if (stall_req !== 1'b0 || aux_count !== 2'd1 || rf_waddr !== 5'(i)) begin
        fails++; $display("FAIL nostarve%0d got stall=%0b cnt=%0d rd=%0d want stall=0 cnt=1 rd=%0d",
                          i, stall_req, aux_count, rf_waddr, i); end
    end
    idle_inputs();
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'hA5) begin
      fails++; $display("FAIL nostarve_drain got we=%0b rd=%0d d=%h want we=1 rd=20 d=a5", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask
`endif

  task automatic test_reset_mid_queue();
    wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h8;
    aux_valid = 1'b1; aux_rd = 5'd3; aux_data = 32'h11;
    tick();
    aux_rd = 5'd4; aux_data = 32'h22;
    tick();
    aux_valid = 1'b0;
    checks++; if (aux_count !== 2'd2) begin fails++; $display("FAIL midrst_pre_count got %0d want 2", aux_count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (aux_count !== 2'd0) begin fails++; $display("FAIL midrst_count got %0d want 0", aux_count); end
    checks++; if (aux_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %0b want 1", aux_ready); end
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL midrst_we got %0b want 0", rf_we); end
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b0 || aux_count !== 2'd0) begin
      fails++; $display("FAIL midrst_after got we=%0b cnt=%0d want we=0 cnt=0", rf_we, aux_count); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_primary();
    test_aux_fill_drain();
    test_contention();
    test_starvation();
    test_reset_mid_queue();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the pipeline's write-back stage (primary) and an auxiliary writer (secondary), such as a multi-cycle multiply/divide unit or a debug loader. The primary writer is served without handshake. Auxiliary writes are queued in a small FIFO and drained on cycles the primary leaves free. An optional starvation guard stalls the pipeline for one cycle so that queued auxiliary writes cannot wait forever. The block sits between WB/aux sources and the register file write port; the register file commits on the following negedge.

## Interface
Parameters:
- AUX_DEPTH, 2: auxiliary queue depth; legal values 2, 4 or 8.
- STARVE_MAX, 4: consecutive denied cycles before the guard fires; legal range 1–15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wb_we  input  1  primary write request.
- wb_rd  input  5  primary destination register.
- wb_data  input  32  primary write data.
- aux_valid  input  1  auxiliary request valid.
- aux_ready  output  1  queue can accept an auxiliary request.
- aux_rd  input  5  auxiliary destination register.
- aux_data  input  32  auxiliary write data.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  register-file write address (registered).
- rf_wdata  output  32  register-file write data (registered).
- stall_req  output  1  pipeline hold request (registered).
- aux_count  output  $clog2(AUX_DEPTH)+1  current queue occupancy.

## Operation
- Primary valid: wb_we=1 and wb_rd≠0. Writes to register 0 are dropped silently, for both the primary and the auxiliary source.
- Auxiliary accept: aux_valid && aux_ready at a posedge pushes {aux_rd, aux_data} at the queue tail. An accepted entry with aux_rd=0 is discarded and not pushed.
- aux_ready = (aux_count < AUX_DEPTH). It is derived from registered occupancy only. A full queue is never ready, even in a cycle where it pops.
- Issue selection each cycle:
  - If stall_req=1 and the queue is non-empty, pop the head and issue it. wb_* is ignored in this cycle.
  - Otherwise, if the primary is valid, issue the primary.
  - Otherwise, if the queue is non-empty, pop the head and issue it.
  - Otherwise, no write: rf_we=0, and rf_waddr/rf_wdata hold their previous values.
- The queue is FIFO-ordered. Read and write pointers wrap modulo AUX_DEPTH. Push and pop in the same cycle leave the count unchanged.
- Ordering between the primary and a queued auxiliary entry to the same register is not reconciled: whichever reaches rf_we later wins.
- Starvation counter (starve_cnt):
  - Increments on each cycle where the queue is non-empty and the primary is issued.
  - Clears when an auxiliary entry is issued or the queue is empty.
  - Saturates at STARVE_MAX.
- stall_req is registered. It is 1 in the cycle after starve_cnt reaches STARVE_MAX, and lasts exactly one cycle per firing.
- Pipeline contract: while stall_req=1, the pipeline holds wb_we, wb_rd and wb_data unchanged and re-presents them in the next cycle.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, aux_count=0, aux_ready=1. Queue pointers and starve_cnt are 0.
- Reset asserted mid-operation discards all queued entries and any pending stall in the same instant.
- Primary latency: wb_we in cycle N → rf_we=1 in cycle N+1. The register file commits at the negedge of N+1.
- Auxiliary latency: accepted in cycle N → earliest rf_we in cycle N+2, provided the primary is idle in N+1.
- Throughput: one register-file write per cycle, maximum.
- Stall timing: the counter reaches STARVE_MAX at the posedge ending cycle N. stall_req=1 during N+1, and the queue head is issued as rf_we=1 in N+2.

## Configuration
- RF_ARB_STARVE_EN defined: the starvation counter and stall_req logic are present, as described above.
- RF_ARB_STARVE_EN undefined: the counter is removed and stall_req is tied to 0. Auxiliary entries drain only on cycles where the primary is idle.

## Test plan
- Reset then idle: rf_we=0, aux_ready=1, aux_count=0, stall_req=0. Asserting reset mid-queue (aux_count=2) clears aux_count to 0 immediately.
- Primary only: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF in cycle N → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1. wb_rd=0 → rf_we stays 0.
- Aux fill/drain, with primary busy: push 2 entries (rd 3 = 0x11, rd 4 = 0x22). Then aux_ready=0 and a third aux_valid is not accepted. Drop the primary → rd 3 is issued, then rd 4, in consecutive cycles, and aux_count goes 2→1→0.
- Contention: primary and aux active in the same cycle with an empty queue → the primary is written first and the aux appears on rf_we one cycle later, once the primary is idle.
- Starvation (macro defined, STARVE_MAX=4): 1 queued entry with the primary valid every cycle → after 4 primary issues, stall_req=1 for one cycle, and the aux entry is written in the following cycle. The held primary write then lands, and none are lost.
- Starvation (macro undefined), same stimulus for 20 cycles → stall_req stays 0 and aux_count stays 1.
